// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative RV32M multiply/divide for the EX stage (1 bit/cycle).
// Revision : 1.0
// ============================================================================
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            annul_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  C_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  C_ONES  = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(XLEN - 1);

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [2*XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                ready_q, ready_d;

    logic                a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       rem_shift;
    logic [XLEN-1:0]     rem_diff;
    logic [2*XLEN-1:0]   iter_acc, prod_signed;
    logic [XLEN-1:0]     quot_signed, rem_signed, final_res;

    // Operand magnitudes and sign decisions at accept time
    always_comb begin
        a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        a_neg    = a_signed & a_i[XLEN-1];
        b_neg    = b_signed & b_i[XLEN-1];
        a_mag    = a_neg ? (~a_i + 1'b1) : a_i;
        b_mag    = b_neg ? (~b_i + 1'b1) : b_i;
    end

    // One iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        rem_shift = acc_q[2*XLEN-1:XLEN-1];
        rem_diff  = rem_shift[XLEN-1:0] - opb_q;
        if (op_q[2]) begin
            if (rem_shift >= {1'b0, opb_q}) begin
                iter_acc = {rem_diff, acc_q[XLEN-2:0], 1'b1};
            end else begin
                iter_acc = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            iter_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;
        end
    end

    always_comb begin
        prod_signed = neg_q ? (~iter_acc + 1'b1) : iter_acc;
        quot_signed = neg_q ? (~iter_acc[XLEN-1:0] + 1'b1) : iter_acc[XLEN-1:0];
        rem_signed  = neg_q ? (~iter_acc[2*XLEN-1:XLEN] + 1'b1) : iter_acc[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            final_res = op_q[1] ? rem_signed : quot_signed;
        end else if (op_q[1:0] == 2'd0) begin
            final_res = prod_signed[XLEN-1:0];
        end else begin
            final_res = prod_signed[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        ready_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d  = op_i;
                    cnt_d = '0;
                    opb_d = b_mag;
                    if (op_i[2]) begin
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        opa_d = '0;
                        neg_d = op_i[1] ? a_neg : (a_neg ^ b_neg);
                        if (b_i == '0) begin
                            result_d = op_i[1] ? a_i : C_ONES;
                            ready_d  = 1'b1;
                            state_d  = S_DONE;
                        end else if (!op_i[0] && (a_i == C_MIN) && (b_i == C_ONES)) begin
                            result_d = op_i[1] ? '0 : C_MIN;
                            ready_d  = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end else begin
                        acc_d   = '0;
                        opa_d   = {{XLEN{1'b0}}, a_mag};
                        neg_d   = a_neg ^ b_neg;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = iter_acc;
                cnt_d = cnt_q + 1'b1;
                if (!op_q[2]) begin
                    opa_d = {opa_q[2*XLEN-2:0], 1'b0};
                    opb_d = {1'b0, opb_q[XLEN-1:1]};
                end
                if (cnt_q == C_LAST) begin
                    result_d = final_res;
                    ready_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A flush abandons everything, including a result being produced
        if (annul_i) begin
            state_d  = S_IDLE;
            ready_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Directed vector bench for ex_muldiv.
// Revision : 1.0
// ============================================================================
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        annul_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE; returns result, cycles to ready and stall-cycle count
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        @(negedge clk);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        lat     = 0;
        stalls  = 0;
        res     = '0;
        #1;
        if (stallreq_o) stalls++;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (stallreq_o) stalls++;
            if (ready_o) break;
        end
        if (ready_o) res = result_o;
        start_i = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          stalls;
        int          pulses;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33};
        vecs[13] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};
        vecs[14] = '{3'd4, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 33};
        vecs[15] = '{3'd4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 33};
        vecs[16] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};
        vecs[17] = '{3'd4, 32'd9,         32'd0,         32'hFFFF_FFFF, 1};

        rst     = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result_o, 32'h0);
        check("reset_ready", {31'd0, ready_o}, 32'h0);
        check("reset_stall", {31'd0, stallreq_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, stalls);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_stalls", i), stalls, vecs[i].lat);
        end

        // Flush during CALC: no pulse, then a fresh op runs normally
        @(negedge clk);
        op_i = 3'd5; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul_stall", {31'd0, stallreq_o}, 32'h0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        pulses  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) pulses++;
        end
        check("annul_no_pulse", pulses, 0);
        run_op(3'd5, 32'd9, 32'd3, res, lat, stalls);
        check("post_annul_result", res, 32'd3);
        check("post_annul_latency", lat, 33);

        // Reset mid-CALC with start still asserted
        @(negedge clk);
        op_i = 3'd0; a_i = 32'd6; b_i = 32'd7; start_i = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_result", result_o, 32'h0);
        check("rst_mid_ready", {31'd0, ready_o}, 32'h0);
        check("rst_mid_stall_hi", {31'd0, stallreq_o}, 32'h1);
        start_i = 1'b0;
        #1;
        check("rst_mid_stall_lo", {31'd0, stallreq_o}, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) pulses++;
        end
        check("rst_mid_no_pulse", pulses, 0);

        // Back-to-back with start held; operands altered mid-CALC must not matter
        @(negedge clk);
        op_i = 3'd0; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
        lat = 0;
        repeat (5) @(negedge clk);
        a_i = 32'd1000; b_i = 32'd1000;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat += (lat == 0) ? 6 : 1;
            if (ready_o) break;
        end
        check("b2b_first_latency", lat, 33);
        check("b2b_first_result", result_o, 32'd15);
        op_i = 3'd5; a_i = 32'd9; b_i = 32'd2;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_o) break;
        end
        check("b2b_second_gap", lat, 34);
        check("b2b_second_result", result_o, 32'd4);
        start_i = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
